// File: rtl/vr_channel_fifo.sv
// vr_channel_fifo: parametrised valid/ready FIFO channel with registered
// handshake flags, occupancy count, almost_full and synchronous flush.
module vr_channel_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_af;
    logic              w_push;
    logic              w_pop;

    // Flush discards any handshake in its cycle.
    always_comb begin
        w_push      = in_valid && r_in_ready && !flush;
        w_pop       = r_out_valid && out_ready && !flush;
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_af        <= 1'b0;
        end else begin
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PW'(1);
                if (w_pop)  r_rptr <= r_rptr + PW'(1);
            end
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt != CW'(DEPTH));
            r_out_valid <= (w_count_nxt != '0);
            r_af        <= (w_count_nxt >= CW'(AF_THRESH));
        end
    end

    // Storage is written only on an accepted push, so idle in_data never lands.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= in_data;
    end

    assign out_data    = r_mem[r_rptr];
    assign in_ready    = r_in_ready && !flush;
    assign out_valid   = r_out_valid;
    assign count       = r_count;
    assign almost_full = r_af;

endmodule

// File: doc/vr_channel_fifo.md
# vr_channel_fifo

Parametrised valid/ready buffering channel placed between a producer and a consumer that share one clock. It generalises the team's 8-bit data/valid/ready producer–consumer link to arbitrary data width and buffer depth. It decouples the two sides with a DEPTH-entry FIFO and exposes occupancy, almost-full and synchronous flush. All handshake outputs are registered so either side can be closed at full clock rate.

## Interface

- DATA_W, 8: payload width in bits (≥1).
- DEPTH, 4: number of storage entries; power of two, ≥2.
- AF_THRESH, DEPTH-1: almost_full asserts when occupancy ≥ AF_THRESH (1..DEPTH).

- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all stored entries.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  buffer can accept; registered.
- in_data  input  DATA_W  producer payload.
- out_valid  output  1  out_data holds a valid entry; registered.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  DATA_W  head-of-queue payload.
- count  output  $clog2(DEPTH+1)  current occupancy; registered.
- almost_full  output  1  count ≥ AF_THRESH; registered.

## Operation

- Push: in_valid && in_ready at a posedge writes in_data at the write pointer, advances it.
- Pop: out_valid && out_ready at a posedge advances the read pointer.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- count next = count + push − pop; push and pop in the same cycle leave count unchanged.
- in_ready = (count != DEPTH) as a registered flag; no push is accepted while full, even if a pop occurs in the same cycle.
- out_valid = (count != 0) as a registered flag; out_data = storage[read pointer]. out_data is stable while out_valid && !out_ready.
- almost_full registered from next-count compare against AF_THRESH.
- flush (highest priority, synchronous): at the posedge where flush=1, pointers and count go to 0 and any push/pop in that cycle is discarded. in_ready is forced 0 combinationally during a flush cycle. Storage contents need not be cleared.
- The producer must hold in_data/in_valid until accepted. The buffer does not check for this and does not reorder. Data order is strictly FIFO.
- X on in_data while in_valid=0 must not propagate to out_data of valid entries.

## Timing

- Reset (rst_n low, asynchronous): count=0, out_valid=0, in_ready=1, almost_full=0 (0 even if AF_THRESH would otherwise apply, since count=0), pointers=0. out_data is don't-care while out_valid=0.
- First posedge after rst_n deassertion can accept a push.
- Latency: a word pushed at posedge t is presented with out_valid=1 from posedge t (visible in cycle t+1). There is no combinational in→out bypass.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Full boundary: count=DEPTH → in_ready=0 from the same edge. A pop at edge t restores in_ready=1 after edge t.
- Empty boundary: count=1 with a pop and no push → out_valid=0 after that edge. Push and pop with count=1 keep out_valid=1 and present the new word.
- rst_n asserted mid-transfer aborts it immediately. No partial state survives.
- flush and rst_n both active: reset dominates.

## Test plan

- Reset: hold rst_n=0 for 3 cycles with random inputs → in_ready=1, out_valid=0, count=0, almost_full=0. Release, then push 0xA5 → out_valid=1 with out_data=0xA5 in the next cycle.
- Fill/drain, DATA_W=8, DEPTH=4, AF_THRESH=3, out_ready=0: push 0x11,0x22,0x33,0x44 → count 1,2,3,4; almost_full rises with count=3; in_ready=0 at count=4. A fifth offer of 0x55 is held, not accepted. Then out_ready=1 → out_data 0x11,0x22,0x33,0x44 in order, then 0x55 after it is accepted.
- Full with simultaneous offer and pop: count=4, in_valid=1, out_ready=1 for one edge → pop only, count=3, in_ready=1 next cycle.
- Streaming wrap: in_valid=out_ready=1 for 20 cycles with incrementing data 0x00..0x13 → every value out exactly once, in order, count steady, pointers wrap at least 4 times.
- Flush: count=3, assert flush for 1 cycle with in_valid=1 and out_ready=1 → count=0, out_valid=0, in_ready=1 next cycle. The pushed word is not later observed.
- Async reset mid-stream: drop rst_n between edges with count=2 → outputs reach reset values before the next posedge, and no stale data is emitted after release.
